// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: one-cycle registered decision, target and link,
// plus a 2-bit saturating branch history table read by fetch and saturating perf counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int AW        = 10,
  parameter int IMM_W     = 20,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             b,
  input  logic             j,
  input  logic             jr,
  input  logic [2:0]       funct3,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  op0,
  input  logic [XLEN-1:0]  op1,
  input  logic [AW-1:0]    address,
  input  logic             pred_taken,
  input  logic [AW-1:0]    fetch_addr,
  output logic             fetch_pred,
  output logic             valid_out,
  output logic             branch,
  output logic [AW-1:0]    targetAddress,
  output logic [AW-1:0]    link_addr,
  output logic             mispredict,
  output logic             misaligned,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int SW    = (XLEN > AW) ? XLEN : AW;

  // Request/response protocol: a request is accepted whenever valid_in is high (no
  // backpressure); its results appear with valid_out one cycle later. Result fields
  // hold across idle cycles and are only meaningful while valid_out is high.

  logic [SW-1:0]   imm_sx;
  logic [SW-1:0]   op0_ext;
  logic [SW-1:0]   addr_ext;
  logic [AW-1:0]   jr_tgt;
  logic [AW-1:0]   pc_tgt;
  logic [AW-1:0]   link_d;

  logic            is_jr;
  logic            is_j;
  logic            is_b;
  logic            any_kind;
  logic            cond_taken;
  logic            cond_legal;
  logic            train;
  logic            taken_d;
  logic [AW-1:0]   tgt_d;
  logic            mis_d;
  logic            count_mis;

  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] fetch_idx;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic             unused_addr_bits;

  logic             valid_q;
  logic             branch_q;
  logic [AW-1:0]    tgt_q;
  logic [AW-1:0]    link_q;
  logic             mis_q;
  logic             misal_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // Operands are widened to the larger of XLEN/AW so the sums are exact before truncation.
  assign imm_sx   = SW'($signed(imm));
  assign op0_ext  = SW'(op0);
  assign addr_ext = SW'(address);
  assign jr_tgt   = AW'(op0_ext + imm_sx) & ~AW'(1);
  assign pc_tgt   = AW'(addr_ext + imm_sx);
  assign link_d   = address + AW'(4);

  assign is_jr    = jr;
  assign is_j     = j & ~jr;
  assign is_b     = b & ~j & ~jr;
  assign any_kind = b | j | jr;

  always_comb begin
    cond_taken = 1'b0;
    cond_legal = 1'b1;
    case (funct3)
      3'b000:  cond_taken = (op0 == op1);
      3'b001:  cond_taken = (op0 != op1);
      3'b100:  cond_taken = ($signed(op0) <  $signed(op1));
      3'b101:  cond_taken = ($signed(op0) >= $signed(op1));
      3'b110:  cond_taken = (op0 <  op1);
      3'b111:  cond_taken = (op0 >= op1);
      default: cond_legal = 1'b0;
    endcase
  end

  always_comb begin
    taken_d = 1'b0;
    tgt_d   = pc_tgt;
    if (is_jr) begin
      taken_d = 1'b1;
      tgt_d   = jr_tgt;
    end else if (is_j) begin
      taken_d = 1'b1;
    end else if (is_b) begin
      taken_d = cond_legal & cond_taken;
    end
  end

  assign train     = valid_in & is_b & cond_legal;
  assign mis_d     = taken_d != pred_taken;
  assign count_mis = valid_in & any_kind & mis_d;

  assign upd_idx   = address[IDX_W+1:2];
  assign fetch_idx = fetch_addr[IDX_W+1:2];
  // Reads the pre-edge array, so a same-cycle update to this index is not visible yet.
  assign fetch_pred = bht_q[fetch_idx][1];
  assign unused_addr_bits = ^{fetch_addr, address};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (train) begin
      if (cond_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      branch_q <= 1'b0;
      tgt_q    <= '0;
      link_q   <= '0;
      mis_q    <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        branch_q <= taken_d;
        tgt_q    <= tgt_d;
        link_q   <= link_d;
        mis_q    <= mis_d;
        misal_q  <= taken_d & (tgt_d[1:0] != 2'b00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (train && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (count_mis && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign valid_out     = valid_q;
  assign branch        = branch_q;
  assign targetAddress = tgt_q;
  assign link_addr     = link_q;
  assign mispredict    = mis_q;
  assign misaligned    = misal_q;
  assign branch_cnt    = branch_cnt_q;
  assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations followed by
// randomized traffic compared each cycle against a behavioural model and expected queue.
module tb_branch_resolve_unit;

  localparam int XLEN    = 32;
  localparam int AW      = 10;
  localparam int IMM_W   = 20;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  localparam longint MASK = 1023;

  logic             clk;
  logic             rst;
  logic             valid_in;
  logic             b;
  logic             j;
  logic             jr;
  logic [2:0]       funct3;
  logic [IMM_W-1:0] imm;
  logic [XLEN-1:0]  op0;
  logic [XLEN-1:0]  op1;
  logic [AW-1:0]    address;
  logic             pred_taken;
  logic [AW-1:0]    fetch_addr;
  logic             fetch_pred;
  logic             valid_out;
  logic             branch;
  logic [AW-1:0]    targetAddress;
  logic [AW-1:0]    link_addr;
  logic             mispredict;
  logic             misaligned;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  branch_resolve_unit #(
    .XLEN(XLEN), .AW(AW), .IMM_W(IMM_W), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .b(b), .j(j), .jr(jr),
    .funct3(funct3), .imm(imm), .op0(op0), .op1(op1), .address(address),
    .pred_taken(pred_taken), .fetch_addr(fetch_addr), .fetch_pred(fetch_pred),
    .valid_out(valid_out), .branch(branch), .targetAddress(targetAddress),
    .link_addr(link_addr), .mispredict(mispredict), .misaligned(misaligned),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          br;
    logic          mis;
    logic          misal;
    logic          tk;
    logic [AW-1:0] tgt;
    logic [AW-1:0] link;
    logic [3:0]    bc;
    logic [3:0]    mc;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int  m_bht[DEPTH];
  bit  m_v, m_br, m_mis, m_misal, m_tk;
  int  m_tgt, m_link, m_bc, m_mc;
  logic fp_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_br = 0; m_mis = 0; m_misal = 0; m_tk = 1;
    m_tgt = 0; m_link = 0; m_bc = 0; m_mc = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
  endtask

  // driver: one cycle of stimulus, model step, and the per-cycle comparison
  task automatic step(input logic v, input logic bb, input logic jj, input logic jjr,
                      input logic [2:0] f3, input logic [19:0] im,
                      input logic [31:0] o0, input logic [31:0] o1,
                      input logic [9:0] ad, input logic pt,
                      input logic [9:0] fa, input logic r);
    longint sx;
    bit     c, legal, any;
    int     idx;
    exp_t   e;
    @(negedge clk);
    rst = r; valid_in = v; b = bb; j = jj; jr = jjr; funct3 = f3; imm = im;
    op0 = o0; op1 = o1; address = ad; pred_taken = pt; fetch_addr = fa;
    #1;
    chk("fetch_pred", fetch_pred, (m_bht[int'(fa[5:2])] >= 2) ? 32'd1 : 32'd0);
    fp_seen = fetch_pred;

    if (r) begin
      model_reset();
    end else if (!v) begin
      m_v = 0;
    end else begin
      m_v = 1;
      sx  = im[19] ? longint'(im) - (longint'(1) << 20) : longint'(im);
      any = 1;
      if (jjr) begin
        m_br = 1; m_tk = 1;
        m_tgt = int'(((longint'(o0) + sx) & MASK) & ~longint'(1));
      end else if (jj) begin
        m_br = 1; m_tk = 1;
        m_tgt = int'((longint'(ad) + sx) & MASK);
      end else if (bb) begin
        m_tk = 1;
        m_tgt = int'((longint'(ad) + sx) & MASK);
        legal = 1; c = 0;
        case (f3)
          3'b000: c = (o0 == o1);
          3'b001: c = (o0 != o1);
          3'b100: c = ($signed(o0) <  $signed(o1));
          3'b101: c = ($signed(o0) >= $signed(o1));
          3'b110: c = (o0 <  o1);
          3'b111: c = (o0 >= o1);
          default: legal = 0;
        endcase
        m_br = legal && c;
        if (legal) begin
          idx = int'(ad[5:2]);
          if (c) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
          else   m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
          m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
        end
      end else begin
        any = 0; m_br = 0; m_tk = 0;
      end
      m_link  = int'((longint'(ad) + 4) & MASK);
      m_mis   = (m_br != pt);
      m_misal = m_br && ((m_tgt & 3) != 0);
      if (any && m_mis) m_mc = (m_mc < CNT_MAX) ? m_mc + 1 : CNT_MAX;
    end
    e.v = m_v; e.br = m_br; e.mis = m_mis; e.misal = m_misal; e.tk = m_tk;
    e.tgt = AW'(m_tgt); e.link = AW'(m_link); e.bc = 4'(m_bc); e.mc = 4'(m_mc);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid_out", valid_out, e.v);
    chk("branch", branch, e.br);
    chk("mispredict", mispredict, e.mis);
    chk("misaligned", misaligned, e.misal);
    chk("link_addr", link_addr, e.link);
    if (e.tk) chk("targetAddress", targetAddress, e.tgt);
    chk("branch_cnt", branch_cnt, e.bc);
    chk("mispred_cnt", mispred_cnt, e.mc);
  endtask

  task automatic idle(input logic [9:0] fa, input logic r);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 20'h0, 32'h0, 32'h0, 10'h0, 1'b0, fa, r);
  endtask

  initial begin
    logic [3:0] pat;
    logic v, bb, jj, jjr, pt, r;
    logic [31:0] o0, o1;
    rst = 1'b1; valid_in = 1'b0; b = 1'b0; j = 1'b0; jr = 1'b0; funct3 = 3'b000;
    imm = '0; op0 = '0; op1 = '0; address = '0; pred_taken = 1'b0; fetch_addr = '0;
    model_reset();

    // reset and post-reset state
    idle(10'h000, 1'b1);
    idle(10'h000, 1'b1);
    idle(10'h00C, 1'b0);
    chk("rst_fetch_pred", fp_seen, 32'd0);
    chk("rst_valid_out", valid_out, 32'd0);
    chk("rst_target", targetAddress, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);

    // BEQ taken backwards
    step(1, 1, 0, 0, 3'b000, 20'hFFFF8, 32'd5, 32'd5, 10'h010, 0, 10'h000, 0);
    chk("beq_branch", branch, 32'd1);
    chk("beq_target", targetAddress, 32'h008);
    chk("beq_link", link_addr, 32'h014);
    chk("beq_mispredict", mispredict, 32'd1);
    chk("beq_branch_cnt", branch_cnt, 32'd1);
    chk("beq_mispred_cnt", mispred_cnt, 32'd1);
    fetch_addr = 10'h010;
    #1;
    chk("beq_bht_pred", fetch_pred, 32'd1);

    // signed vs unsigned compare, illegal funct3
    step(1, 1, 0, 0, 3'b100, 20'h10, 32'hFFFF_FFFF, 32'd1, 10'h044, 0, 10'h000, 0);
    chk("blt_branch", branch, 32'd1);
    step(1, 1, 0, 0, 3'b110, 20'h10, 32'hFFFF_FFFF, 32'd1, 10'h044, 0, 10'h000, 0);
    chk("bltu_branch", branch, 32'd0);
    step(1, 1, 0, 0, 3'b010, 20'h10, 32'd3, 32'd3, 10'h044, 0, 10'h000, 0);
    chk("f3_010_branch", branch, 32'd0);
    chk("f3_010_cnt", branch_cnt, 32'd3);

    // JALR clears bit 0, JAL may be misaligned
    step(1, 0, 0, 1, 3'b000, 20'h2, 32'h203, 32'h0, 10'h100, 1, 10'h000, 0);
    chk("jalr_target", targetAddress, 32'h204);
    chk("jalr_misaligned", misaligned, 32'd0);
    step(1, 0, 1, 0, 3'b000, 20'h2, 32'h0, 32'h0, 10'h100, 1, 10'h000, 0);
    chk("jal_target", targetAddress, 32'h102);
    chk("jal_misaligned", misaligned, 32'd1);
    chk("jal_branch", branch, 32'd1);
    fetch_addr = 10'h100;
    #1;
    chk("jump_no_train", fetch_pred, 32'd0);

    // BHT saturation with same-cycle lookup showing the pre-update value
    pat = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 0, 3'b001, 20'h8, 32'd1, 32'd2, 10'h020, 1, 10'h020, 0);
      chk("bne_prelookup", fp_seen, 32'(pat[k]));
    end
    fetch_addr = 10'h020;
    #1;
    chk("bne_saturated", fetch_pred, 32'd1);

    // address wrap
    step(1, 0, 1, 0, 3'b000, 20'h8, 32'h0, 32'h0, 10'h3FC, 1, 10'h000, 0);
    chk("wrap_target", targetAddress, 32'h004);
    chk("wrap_link", link_addr, 32'h000);

    // reset mid-stream drops the request in the reset cycle
    step(1, 1, 0, 0, 3'b000, 20'h4, 32'd7, 32'd7, 10'h010, 0, 10'h000, 0);
    step(1, 1, 0, 0, 3'b000, 20'h4, 32'd7, 32'd7, 10'h010, 0, 10'h000, 1);
    chk("mid_rst_valid", valid_out, 32'd0);
    chk("mid_rst_branch", branch, 32'd0);
    chk("mid_rst_target", targetAddress, 32'd0);
    chk("mid_rst_link", link_addr, 32'd0);
    chk("mid_rst_bcnt", branch_cnt, 32'd0);
    chk("mid_rst_mcnt", mispred_cnt, 32'd0);
    idle(10'h010, 1'b0);
    chk("mid_rst_bht", fp_seen, 32'd0);
    chk("mid_rst_idle_valid", valid_out, 32'd0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      v   = ($urandom_range(0, 4) != 0);
      bb  = ($urandom_range(0, 3) != 0);
      jj  = ($urandom_range(0, 5) == 0);
      jjr = ($urandom_range(0, 5) == 0);
      pt  = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 199) == 0);
      o0  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      o1  = ($urandom_range(0, 2) == 0) ? o0 : (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) : $urandom);
      step(v, bb, jj, jjr, 3'($urandom_range(0, 7)), 20'($urandom), o0, o1,
           ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7) * 4),
           pt, 10'($urandom), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
